// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl
// Hazard and stall controller for the 5-stage RV32I pipeline.
// It drives the stall and flush controls of the F/D/E/M pipeline registers.
// It detects load-use and taken-branch hazards and selects execute-stage
// operand forwarding. It freezes the pipeline while a data-memory access is
// outstanding. After reset it flushes the pipeline for INIT_CYC cycles.
//
// Parameters:
//   DPW       datapath width (not used internally)
//   INIT_CYC  post-reset flush cycles, 1..15
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   rs1D, rs2D                  decode source registers
//   rs1E, rs2E                  execute source registers
//   rdE, rdM, rdW               destination registers per stage
//   regwriteE/M/W               register-write enables per stage
//   loadE                       execute instruction is a load
//   pcsrcE                      taken branch/jump resolved in execute
//   dmem_valid, dmem_ready      data-memory request / completion
//   stallF/D/E/M                hold pipeline registers
//   flushD, flushE              clear decode / execute register to a NOP
//   forwardAE, forwardBE        00 regfile, 01 writeback, 10 memory ALU result
//   busy                        controller not in RUN
//
// Build option: define RV32I_HZ_FWD_EN to enable operand forwarding.
// Without it, forwarding is tied off and decode stalls on any RAW
// dependency against E or M.
module rv32i_hazard_ctrl #(
  parameter int DPW      = 32,
  parameter int INIT_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       loadE,
  input  logic       pcsrcE,
  input  logic       dmem_valid,
  input  logic       dmem_ready,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       busy
);

  if (DPW < 1 || INIT_CYC < 1 || INIT_CYC > 15) begin : g_param_check
    $error("rv32i_hazard_ctrl: DPW must be >= 1 and INIT_CYC must be 1..15");
  end

  typedef enum logic [1:0] {INIT, RUN, MEMWAIT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(INIT_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       dec_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_stall;
  logic       unused_inputs;

  // Not every input feeds logic in every build configuration.
  assign unused_inputs = ^{loadE, regwriteE, rs1E, rs2E, rdW, regwriteW};

`ifdef RV32I_HZ_FWD_EN
  // Only a load needs a decode stall; ALU results reach E by forwarding.
  assign dec_stall = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  // M has priority over W because it holds the younger result.
  assign fwd_a = (regwriteM && (rdM != 5'd0) && (rdM == rs1E)) ? 2'b10 :
                 (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) ? 2'b01 : 2'b00;
  assign fwd_b = (regwriteM && (rdM != 5'd0) && (rdM == rs2E)) ? 2'b10 :
                 (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) ? 2'b01 : 2'b00;
`else
  // No bypass paths: decode waits for any E/M producer to retire. W is not
  // checked because the register file writes in the first half-cycle.
  assign dec_stall = (regwriteE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D))) ||
                     (regwriteM && (rdM != 5'd0) && ((rdM == rs1D) || (rdM == rs2D)));
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= CNT_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    mem_stall = 1'b0;
    busy      = (state != RUN);

    case (state)
      INIT: begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      RUN, MEMWAIT: begin
        forwardAE = fwd_a;
        forwardBE = fwd_b;
        // In MEMWAIT the access is already outstanding; only ready ends it.
        // The ready cycle itself is a normal cycle, so N not-ready cycles
        // give exactly N stall cycles.
        if (state == MEMWAIT) begin
          mem_stall = !dmem_ready;
        end else begin
          mem_stall = dmem_valid && !dmem_ready;
        end

        if (mem_stall) begin
          stallF    = 1'b1;
          stallD    = 1'b1;
          stallE    = 1'b1;
          stallM    = 1'b1;
          state_nxt = MEMWAIT;
        end else begin
          state_nxt = RUN;
          // A taken branch discards the stalled decode instruction anyway,
          // so it overrides the decode stall.
          if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (dec_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule
